// File: rtl/enc_event_fifo_if.sv
// enc_event_fifo_if: encoder input, FIFO drain handshake and status signals of enc_event_fifo.
interface enc_event_fifo_if #(parameter int DEPTH = 4);
   logic [1:0]              code_in;
   logic                    valid_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [1:0]              out_code;
   logic [$clog2(DEPTH):0]  level;
   logic                    overflow;
   logic                    clr_ovf;
   modport master (output code_in, valid_in, out_ready, clr_ovf,
                   input  out_valid, out_code, level, overflow);
   modport slave  (input  code_in, valid_in, out_ready, clr_ovf,
                   output out_valid, out_code, level, overflow);
endinterface

// File: rtl/enc_event_fifo.sv
// enc_event_fifo: synchronises encoder code/valid, detects encode events and queues their codes for a ready/valid consumer.
module enc_event_fifo #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic              clk,
   input logic              rst_n,
   enc_event_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   logic [1:0]  code_s;
   logic        valid_s;
   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign code_s  = bus.code_in;
         assign valid_s = bus.valid_in;
      end else begin : g_sync
         logic [2:0] sync_q [SYNC_STAGES];
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
               sync_q[0] <= {bus.valid_in, bus.code_in};
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         assign {valid_s, code_s} = sync_q[SYNC_STAGES-1];
      end
   endgenerate
   logic         prev_valid_q, push_q, ovf_q, ovf_d;
   logic [1:0]   prev_code_q, push_code_q;
   logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]   mem_q [DEPTH];
   logic         evt, empty, full, pop, wr_en, drop;
   // A pop frees the slot the same cycle, so a push into a full FIFO still lands when the head leaves.
   always_comb begin
      evt      = valid_s & (~prev_valid_q | (code_s != prev_code_q));
      empty    = wr_ptr_q == rd_ptr_q;
      full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) & (wr_ptr_q[AW] != rd_ptr_q[AW]);
      pop      = ~empty & bus.out_ready;
      wr_en    = push_q & (~full | pop);
      drop     = push_q & ~wr_en;
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      ovf_d    = drop ? 1'b1 : bus.clr_ovf ? 1'b0 : ovf_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         prev_valid_q <= 1'b0;
         prev_code_q  <= '0;
         push_q       <= 1'b0;
         push_code_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ovf_q        <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         prev_valid_q <= valid_s;
         prev_code_q  <= code_s;
         push_q       <= evt;
         push_code_q  <= code_s;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ovf_q        <= ovf_d;
         if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_code_q;
      end
   assign bus.out_valid = ~empty;
   assign bus.out_code  = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.level     = wr_ptr_q - rd_ptr_q;
   assign bus.overflow  = ovf_q;
endmodule
